uart_tx_sched: RTL and testbench

- Shares the board's single serial transmit line between two byte requesters: port 0 is the CPU and port 1 is the debug monitor.
- Arbitrates round-robin and serializes each granted byte as an 8N1 UART frame.
- Drives TxD toward the CPLD serial routing.
- Replaces the direct pin passthrough when more than one on-chip source must talk on the same line.

---
 rtl/uart_tx_sched.sv | 134 +++++++++++++
 tb/tb_uart_tx_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// Ports: clk/rst, en, req{0,1}_{valid,data,ready}, TxD, busy, grant_id, frame_done.
module uart_tx_sched #(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       TxD,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             last_grant, last_d;
  logic             gid_d, txd_d;
  logic             sel, accept, expire, can_grant;

  // Tie goes to the port that did not win last time.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid)
      sel = ~last_grant;
  end

  assign can_grant  = rst && en && (state == IDLE);
  assign req0_ready = can_grant && req0_valid && !sel;
  assign req1_ready = can_grant && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign expire     = (cnt == '0);
  assign busy       = (state != IDLE);
  assign frame_done = rst && (state == STOP) && expire;

  // TxD is registered, so the value computed here is what the line
  // shows during the cycle after the edge.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shreg_d = shreg;
    last_d  = last_grant;
    gid_d   = grant_id;
    txd_d   = TxD;
    unique case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shreg_d = sel ? req1_data : req0_data;
          gid_d   = sel;
          last_d  = sel;
          cnt_d   = RELOAD;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (expire) begin
          cnt_d   = RELOAD;
          idx_d   = 3'd0;
          state_d = DATA;
          txd_d   = shreg[0];
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      DATA: begin
        if (expire) begin
          cnt_d = RELOAD;
          if (idx == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx + 3'd1;
            txd_d = shreg[idx + 3'd1];
          end
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      STOP: begin
        if (expire) begin
          cnt_d   = RELOAD;
          state_d = IDLE;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shreg      <= 8'h00;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      TxD        <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shreg      <= shreg_d;
      last_grant <= last_d;
      grant_id   <= gid_d;
      TxD        <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with CLK_DIV=4.
// Vector table for idle arbitration, hand sequences for frames.
module tb_uart_tx_sched;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       TxD;
  logic       busy;
  logic       grant_id;
  logic       frame_done;

  int n_pass = 0;
  int n_total = 0;

  uart_tx_sched #(.CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .TxD        (TxD),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic en;
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Call in the acceptance cycle; returns in the last stop-bit cycle.
  task automatic expect_frame(input logic [7:0] d, input logic id,
                              input bit poke, input bit drop);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int k = 1; k <= 10 * DIV; k++) begin
      tick();
      if (k == 10) begin
        if (poke) req0_data = ~req0_data;
        if (drop) en = 1'b0;
      end
      chk1("txd", TxD, fr[(k - 1) / DIV]);
      chk1("busy", busy, 1'b1);
      chk1("frame_done", frame_done, k == 10 * DIV);
      chk1("grant_id", grant_id, id);
      chk1("r0_in_frame", req0_ready, 1'b0);
      chk1("r1_in_frame", req1_ready, 1'b0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // reset state
    tick();
    tick();
    chk1("rst_txd", TxD, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_gid", grant_id, 1'b0);
    chk1("rst_fd", frame_done, 1'b0);
    req0_valid = 1'b1;
    en = 1'b1;
    #1;
    chk1("rst_no_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    tick();

    // idle arbitration table; valids dropped before each edge
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en;
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      #1;
      chk1($sformatf("tbl%0d_r0", i), req0_ready, tbl[i].r0);
      chk1($sformatf("tbl%0d_r1", i), req1_ready, tbl[i].r1);
      chk1($sformatf("tbl%0d_txd", i), TxD, 1'b1);
      chk1($sformatf("tbl%0d_busy", i), busy, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
    end

    // single byte A5 from port 0
    en = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'hA5;
    #1;
    chk1("a5_r0", req0_ready, 1'b1);
    chk1("a5_r1", req1_ready, 1'b0);
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b0;
    tick();
    chk1("a5_idle_busy", busy, 1'b0);
    chk1("a5_idle_txd", TxD, 1'b1);
    chk1("a5_idle_gid", grant_id, 1'b0);

    // tie and alternation from reset
    do_reset();
    en = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h11;
    req1_valid = 1'b1;
    req1_data = 8'h22;
    #1;
    chk1("alt0_r0", req0_ready, 1'b1);
    chk1("alt0_r1", req1_ready, 1'b0);
    expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
    for (int f = 1; f < 4; f++) begin
      tick();
      chk1($sformatf("alt%0d_r0", f), req0_ready, f[0] == 1'b0);
      chk1($sformatf("alt%0d_r1", f), req1_ready, f[0] == 1'b1);
      if (f[0]) expect_frame(8'h22, 1'b1, 1'b0, 1'b0);
      else      expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk1("alt_end_busy", busy, 1'b0);

    // port 1 streaming alone
    req1_valid = 1'b1;
    req1_data = 8'h5A;
    #1;
    chk1("st0_r1", req1_ready, 1'b1);
    chk1("st0_r0", req0_ready, 1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    tick();
    chk1("st1_r1", req1_ready, 1'b1);
    chk1("st1_r0", req0_ready, 1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    req1_valid = 1'b0;
    tick();

    // en low blocks grants
    en = 1'b0;
    req0_valid = 1'b1;
    req0_data = 8'hC3;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk1("en0_r0", req0_ready, 1'b0);
      chk1("en0_txd", TxD, 1'b1);
      chk1("en0_busy", busy, 1'b0);
    end

    // en dropped mid-frame
    en = 1'b1;
    #1;
    chk1("endrop_r0", req0_ready, 1'b1);
    expect_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk1("endrop_r0_after", req0_ready, 1'b0);
      chk1("endrop_busy", busy, 1'b0);
      chk1("endrop_txd", TxD, 1'b1);
    end
    req0_valid = 1'b0;
    en = 1'b1;

    // reset during data bit 3
    req1_valid = 1'b1;
    req1_data = 8'hF0;
    #1;
    chk1("mid_r1", req1_ready, 1'b1);
    tick();
    req1_valid = 1'b0;
    repeat (16) tick();
    chk1("mid_busy", busy, 1'b1);
    chk1("mid_gid", grant_id, 1'b1);
    chk1("mid_bit3", TxD, 1'b0);
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_data = 8'h96;
    req1_valid = 1'b1;
    #1;
    chk1("rstlow_r0", req0_ready, 1'b0);
    chk1("rstlow_r1", req1_ready, 1'b0);
    tick();
    chk1("rstmid_txd", TxD, 1'b1);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_gid", grant_id, 1'b0);
    rst = 1'b1;
    #1;
    chk1("post_rst_r0", req0_ready, 1'b1);
    chk1("post_rst_r1", req1_ready, 1'b0);
    // req0_data flips mid-frame; the latched 96 must still go out
    expect_frame(8'h96, 1'b0, 1'b1, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk1("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
